btb_update_queue: RTL and testbench
===================================

BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset==0 at a rising edge resets all state.
REQ-004 ex_valid  input  1  execute stage resolved a branch this cycle.
REQ-005 ex_pc  input  32  PC of the resolved branch bundle.
REQ-006 ex_target  input  32  resolved target.
REQ-007 ex_taken  input  1  branch resolved taken.
REQ-008 ex_mispredict  input  1  front-end prediction was wrong.
REQ-009 ex_type  input  2  branch type: 0 None, 1 Call, 2 Return, 3 Other.
REQ-010 ex_location  input  1  slot of the branch within the fetch pair.
REQ-011 btb_busy  input  1  BTB write port unavailable this cycle; no dequeue.
REQ-012 upd_valid  output  1  head entry presented to the BTB.
REQ-013 upd_pc, upd_target  output  32 each  head entry PC and target.
REQ-014 upd_taken, upd_mispredict  output  1 each  head entry flags.
REQ-015 upd_type  output  2; upd_location  output  1  head entry fields.
REQ-016 count  output  clog2(DEPTH)+1  current occupancy.
REQ-017 drop_cnt  output  8  saturating count of filtered updates lost to a full queue.

Function
REQ-018 Filter: an input is "filtered" iff ex_valid & ex_taken & ex_mispredict; other inputs are ignored and change no state.
REQ-019 Storage: circular buffer; head/tail pointers wrap modulo DEPTH; separate occupancy counter distinguishes full from empty.
REQ-020 Outputs driven from the head entry registers; upd_valid = (count != 0); upd_* fields hold the last head contents when empty.
REQ-021 Dequeue: occurs at an edge iff upd_valid & ~btb_busy; the head pointer advances by 1.
REQ-022 Latency: a filtered input accepted at edge N into an empty queue appears on upd_valid/upd_* in the cycle after edge N (no same-cycle bypass).
REQ-023 Coalesce: if a filtered input has ex_pc equal to the tail entry's PC, and that tail entry is valid and not being dequeued at this edge, it overwrites the tail entry in place; count is unchanged.
REQ-024 Enqueue: a filtered, non-coalesced input writes at the tail and the tail pointer advances, provided count < DEPTH or a dequeue occurs at the same edge.
REQ-025 Full drop: a filtered, non-coalesced input with count == DEPTH and no dequeue at that edge is discarded; drop_cnt increments and saturates at 255.
REQ-026 Simultaneous enqueue and dequeue: count is unchanged; both pointers advance.
REQ-027 Count never exceeds DEPTH and never underflows.
REQ-028 Entry order is preserved: entries dequeue in enqueue order, and coalescing keeps the tail's position.

Reset
REQ-029 With reset==0 at an edge: head = tail = 0, count = 0, upd_valid = 0, drop_cnt = 0, all stored entry fields = 0.
REQ-030 Reset overrides any concurrent enqueue or dequeue; a filtered input in the reset cycle is lost.
REQ-031 Reset asserted mid-operation empties the queue immediately; upd_valid is 0 in the following cycle.

Verification
REQ-032 Single update: empty queue, filtered input pc=0x8000_0010, target=0x8000_0100 at edge 1, btb_busy=0 -> cycle after edge 1: upd_valid=1 with those values; after edge 2: upd_valid=0, count=0.
REQ-033 Filtering: ex_valid=1, ex_taken=1, ex_mispredict=0 -> count stays 0, upd_valid stays 0; ex_taken=0, ex_mispredict=1 -> same.
REQ-034 Full and drop: btb_busy=1, 5 distinct filtered PCs with DEPTH=4 -> count=4, drop_cnt=1; release btb_busy -> 4 entries dequeue in order over 4 cycles.
REQ-035 Coalesce: btb_busy=1, enqueue pc=A target=T1, then pc=A target=T2 -> count=1, head target=T2; with count=1 and a dequeue at the same edge, a same-PC input enqueues instead (count stays 1 after the edge, new entry at head).
REQ-036 Full plus simultaneous: count=4, btb_busy=0, distinct filtered input -> accepted, count stays 4, drop_cnt unchanged; drop_cnt saturation: 300 drops -> 255.
REQ-037 Reset mid-stream: count=3, reset=0 for one edge -> count=0, upd_valid=0, drop_cnt=0 next cycle; normal enqueue resumes afterwards.

Source files
------------

// File: rtl/btb_update_queue.sv
// Coalescing FIFO that buffers taken-mispredict branch resolutions until the
// BTB write port is free; the head entry drives the BTB update outputs.
module btb_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_valid,
  input  logic [31:0]            ex_pc,
  input  logic [31:0]            ex_target,
  input  logic                   ex_taken,
  input  logic                   ex_mispredict,
  input  logic [1:0]             ex_type,
  input  logic                   ex_location,
  input  logic                   btb_busy,
  output logic                   upd_valid,
  output logic [31:0]            upd_pc,
  output logic [31:0]            upd_target,
  output logic                   upd_taken,
  output logic                   upd_mispredict,
  output logic [1:0]             upd_type,
  output logic                   upd_location,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
    logic [1:0]  btype;
    logic        location;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] last_idx, show_idx;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic          filt, deq, coalesce, enq, drop;
  entry_t        in_entry;

  // A single-entry queue being drained this edge cannot absorb a coalesce,
  // so the new update is enqueued behind it instead.
  always_comb begin
    filt     = ex_valid & ex_taken & ex_mispredict;
    deq      = (count_q != '0) & ~btb_busy;
    last_idx = tail_q - PW'(1);
    in_entry = '{pc: ex_pc, target: ex_target, taken: ex_taken,
                 mispredict: ex_mispredict, btype: ex_type,
                 location: ex_location};
    coalesce = filt & (count_q != '0) & (mem_q[last_idx].pc == ex_pc)
             & ~(deq & (count_q == CW'(1)));
    enq      = filt & ~coalesce & ((count_q != FULL) | deq);
    drop     = filt & ~coalesce & (count_q == FULL) & ~deq;

    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (coalesce)  mem_d[last_idx] = in_entry;
    else if (enq)  mem_d[tail_q]   = in_entry;

    head_d  = deq ? head_q + PW'(1) : head_q;
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enq) - CW'(deq);
    drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // When empty, the slot just behind head is the most recently drained entry.
  always_comb begin
    show_idx = (count_q != '0) ? head_q : head_q - PW'(1);
  end

  assign upd_valid      = (count_q != '0);
  assign upd_pc         = mem_q[show_idx].pc;
  assign upd_target     = mem_q[show_idx].target;
  assign upd_taken      = mem_q[show_idx].taken;
  assign upd_mispredict = mem_q[show_idx].mispredict;
  assign upd_type       = mem_q[show_idx].btype;
  assign upd_location   = mem_q[show_idx].location;
  assign count          = count_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: directed vectors push expected
// entries, a negedge monitor compares the head and occupancy every cycle.
module tb_btb_update_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
    logic [1:0]  btype;
    logic        location;
  } exp_t;

  typedef enum {ACT_IGNORE, ACT_ENQ, ACT_COAL, ACT_DROP} act_e;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        ex_taken = 1'b0;
  logic        ex_mispredict = 1'b0;
  logic [1:0]  ex_type = '0;
  logic        ex_location = 1'b0;
  logic        btb_busy = 1'b1;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic        upd_taken, upd_mispredict, upd_location;
  logic [1:0]  upd_type;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  exp_t sb[$];
  exp_t last_out = '0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  btb_update_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
    .ex_type(ex_type), .ex_location(ex_location), .btb_busy(btb_busy),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .upd_type(upd_type), .upd_location(upd_location),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
  endtask

  task automatic checkEntry(input string name, input exp_t actual, input exp_t expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
  endtask

  // Drives one execute-stage vector for one edge, then records the
  // hand-chosen outcome in the scoreboard once the edge has happened.
  task automatic applyStimulus(input bit v, input bit t, input bit m,
                               input logic [31:0] pc, input logic [31:0] tgt,
                               input logic [1:0] typ, input bit loc, input act_e act);
    exp_t e;
    ex_valid = v; ex_taken = t; ex_mispredict = m;
    ex_pc = pc; ex_target = tgt; ex_type = typ; ex_location = loc;
    e = '{pc: pc, target: tgt, taken: t, mispredict: m, btype: typ, location: loc};
    @(posedge clk);
    case (act)
      ACT_ENQ:  sb.push_back(e);
      ACT_COAL: if (sb.size() != 0) sb[sb.size()-1] = e;
      default:  ;
    endcase
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(posedge clk);
    sb.delete();
    last_out = '0;
    #1;
    reset = 1'b1;
  endtask

  // Monitor: occupancy, valid, head contents, and held contents when empty.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("count", 32'(count), 32'(sb.size()));
      checkOutput("upd_valid", 32'(upd_valid), 32'(sb.size() != 0));
      if (upd_valid && sb.size() != 0) begin
        checkEntry("head_entry",
                   {upd_pc, upd_target, upd_taken, upd_mispredict, upd_type, upd_location},
                   sb[0]);
        if (!btb_busy) last_out = sb.pop_front();
      end else if (!upd_valid) begin
        checkEntry("held_entry",
                   {upd_pc, upd_target, upd_taken, upd_mispredict, upd_type, upd_location},
                   last_out);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    btb_busy = 1'b1;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_valid", 32'(upd_valid), 32'd0);
    checkOutput("reset_drop", 32'(drop_cnt), 32'd0);
    mon_en = 1'b1;

    // Single update, one-cycle latency then drained
    btb_busy = 1'b0;
    applyStimulus(1, 1, 1, 32'h8000_0010, 32'h8000_0100, 2'd3, 1'b0, ACT_ENQ);
    idle(2);
    checkOutput("single_count", 32'(count), 32'd0);

    // Unfiltered inputs change nothing
    applyStimulus(1, 1, 0, 32'h8000_0020, 32'h1111_1111, 2'd1, 1'b1, ACT_IGNORE);
    applyStimulus(1, 0, 1, 32'h8000_0024, 32'h2222_2222, 2'd2, 1'b0, ACT_IGNORE);
    applyStimulus(0, 1, 1, 32'h8000_0028, 32'h3333_3333, 2'd3, 1'b1, ACT_IGNORE);
    checkOutput("filter_count", 32'(count), 32'd0);
    checkOutput("filter_valid", 32'(upd_valid), 32'd0);

    // Full and drop, then ordered drain
    btb_busy = 1'b1;
    applyStimulus(1, 1, 1, 32'h0000_1000, 32'hA000_0000, 2'd1, 1'b0, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_1004, 32'hA000_0004, 2'd2, 1'b1, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_1008, 32'hA000_0008, 2'd3, 1'b0, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_100C, 32'hA000_000C, 2'd0, 1'b1, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_1010, 32'hA000_0010, 2'd1, 1'b0, ACT_DROP);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_drop", 32'(drop_cnt), 32'd1);
    btb_busy = 1'b0;
    idle(4);
    checkOutput("drain_count", 32'(count), 32'd0);

    // Coalesce into single entry, then same-PC input while that entry drains
    btb_busy = 1'b1;
    applyStimulus(1, 1, 1, 32'h0000_2000, 32'hB000_0001, 2'd3, 1'b0, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_2000, 32'hB000_0002, 2'd3, 1'b1, ACT_COAL);
    checkOutput("coal_count", 32'(count), 32'd1);
    checkOutput("coal_target", upd_target, 32'hB000_0002);
    btb_busy = 1'b0;
    applyStimulus(1, 1, 1, 32'h0000_2000, 32'hB000_0003, 2'd3, 1'b0, ACT_ENQ);
    checkOutput("coal_deq_count", 32'(count), 32'd1);
    checkOutput("coal_deq_target", upd_target, 32'hB000_0003);
    idle(2);

    // Coalesce into a tail that is not the head
    btb_busy = 1'b1;
    applyStimulus(1, 1, 1, 32'h0000_3000, 32'hC000_0000, 2'd1, 1'b0, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_3004, 32'hC000_0004, 2'd2, 1'b0, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_3004, 32'hC000_0044, 2'd2, 1'b1, ACT_COAL);
    checkOutput("coal_tail_count", 32'(count), 32'd2);
    btb_busy = 1'b0;
    idle(3);

    // Full plus simultaneous dequeue, then drop saturation
    btb_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 1, 32'h0000_4000 + 32'(i * 4), 32'hD000_0000 + 32'(i), 2'd3, 1'b0, ACT_ENQ);
    btb_busy = 1'b0;
    applyStimulus(1, 1, 1, 32'h0000_4010, 32'hD000_0004, 2'd3, 1'b1, ACT_ENQ);
    checkOutput("simul_count", 32'(count), 32'd4);
    checkOutput("simul_drop", 32'(drop_cnt), 32'd1);
    btb_busy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, 1, 32'h9000_0000 + 32'(i * 4), 32'hE000_0000, 2'd3, 1'b0, ACT_DROP);
      if (i == 99) checkOutput("drop_101", 32'(drop_cnt), 32'd101);
    end
    checkOutput("drop_sat", 32'(drop_cnt), 32'd255);
    btb_busy = 1'b0;
    idle(5);

    // Reset mid-stream, then normal operation resumes
    btb_busy = 1'b1;
    applyStimulus(1, 1, 1, 32'h0000_5000, 32'hF000_0000, 2'd1, 1'b0, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_5004, 32'hF000_0004, 2'd2, 1'b1, ACT_ENQ);
    applyStimulus(1, 1, 1, 32'h0000_5008, 32'hF000_0008, 2'd3, 1'b0, ACT_ENQ);
    checkOutput("pre_reset_count", 32'(count), 32'd3);
    doReset();
    checkOutput("mid_reset_count", 32'(count), 32'd0);
    checkOutput("mid_reset_valid", 32'(upd_valid), 32'd0);
    checkOutput("mid_reset_drop", 32'(drop_cnt), 32'd0);
    btb_busy = 1'b0;
    applyStimulus(1, 1, 1, 32'h0000_6000, 32'h1234_5678, 2'd2, 1'b1, ACT_ENQ);
    checkOutput("resume_valid", 32'(upd_valid), 32'd1);
    idle(3);
    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
